// File: rtl/watch_cal_top.sv
// Calendar watch: programmable prescaler drives sec/min/hour fields and a free-running day count.
// Define WATCH_CAL_ALARM_EN to build the hour:minute alarm; otherwise o_alarm is tied low.
module watch_cal_top #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_SEC_BIT   = 6,
    parameter int P_MIN_BIT   = 6,
    parameter int P_HOUR_BIT  = 5,
    parameter int P_DAY_BIT   = 10,
    parameter int P_HOUR_MAX  = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run_en,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    input  logic                   i_set_valid,
    input  logic [P_SEC_BIT-1:0]   i_set_sec,
    input  logic [P_MIN_BIT-1:0]   i_set_min,
    input  logic [P_HOUR_BIT-1:0]  i_set_hour,
    input  logic                   i_alarm_en,
    input  logic [P_MIN_BIT-1:0]   i_alarm_min,
    input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
    output logic                   o_tick,
    output logic [P_SEC_BIT-1:0]   o_sec,
    output logic [P_MIN_BIT-1:0]   o_min,
    output logic [P_HOUR_BIT-1:0]  o_hour,
    output logic [P_DAY_BIT-1:0]   o_day,
    output logic                   o_set_err,
    output logic                   o_alarm
);

    localparam logic [P_SEC_BIT-1:0]  SEC_LAST  = P_SEC_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]  MIN_LAST  = P_MIN_BIT'(59);
    localparam logic [P_HOUR_BIT-1:0] HOUR_LAST = P_HOUR_BIT'(P_HOUR_MAX - 1);

    logic [P_COUNT_BIT-1:0] prescaler;
    logic [P_COUNT_BIT:0]   prescaler_inc;
    logic                   tick_due;
    logic                   set_ok;
    logic                   load;
    logic                   advance;
    logic [P_SEC_BIT-1:0]   next_sec;
    logic [P_MIN_BIT-1:0]   next_min;
    logic [P_HOUR_BIT-1:0]  next_hour;
    logic [P_DAY_BIT-1:0]   next_day;

    // prescaler+1 >= i_freq also covers i_freq of 0/1 and a frequency lowered mid-count
    assign prescaler_inc = {1'b0, prescaler} + {{P_COUNT_BIT{1'b0}}, 1'b1};
    assign tick_due      = i_run_en && (prescaler_inc >= {1'b0, i_freq});

    assign set_ok  = (i_set_sec <= SEC_LAST) && (i_set_min <= MIN_LAST) && (i_set_hour <= HOUR_LAST);
    assign load    = i_set_valid && set_ok;
    assign advance = tick_due && !load;

    always_comb begin
        next_sec  = o_sec + P_SEC_BIT'(1);
        next_min  = o_min;
        next_hour = o_hour;
        next_day  = o_day;
        if (o_sec == SEC_LAST) begin
            next_sec = '0;
            next_min = o_min + P_MIN_BIT'(1);
            if (o_min == MIN_LAST) begin
                next_min  = '0;
                next_hour = o_hour + P_HOUR_BIT'(1);
                if (o_hour == HOUR_LAST) begin
                    next_hour = '0;
                    next_day  = o_day + P_DAY_BIT'(1);
                end
            end
        end
    end

    // A valid load wins over a due tick; a rejected load still lets the tick through.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            o_sec     <= '0;
            o_min     <= '0;
            o_hour    <= '0;
            o_day     <= '0;
            o_tick    <= 1'b0;
            o_set_err <= 1'b0;
        end else begin
            o_tick    <= 1'b0;
            o_set_err <= i_set_valid && !set_ok;
            if (load) begin
                prescaler <= '0;
                o_sec     <= i_set_sec;
                o_min     <= i_set_min;
                o_hour    <= i_set_hour;
            end else if (advance) begin
                prescaler <= '0;
                o_sec     <= next_sec;
                o_min     <= next_min;
                o_hour    <= next_hour;
                o_day     <= next_day;
                o_tick    <= 1'b1;
            end else if (i_run_en) begin
                prescaler <= prescaler_inc[P_COUNT_BIT-1:0];
            end
        end
    end

`ifdef WATCH_CAL_ALARM_EN
    logic alarm_hit;

    assign alarm_hit = i_alarm_en && (next_sec == '0) && (next_min == i_alarm_min)
                       && (next_hour == i_alarm_hour);

    always_ff @(posedge clk) begin
        if (reset) begin
            o_alarm <= 1'b0;
        end else begin
            o_alarm <= advance && alarm_hit;
        end
    end
`else
    logic unused_alarm;

    assign unused_alarm = ^{i_alarm_en, i_alarm_min, i_alarm_hour};
    assign o_alarm      = 1'b0;
`endif

endmodule
